ddram_arb: RTL
==============

DDRAM_ARB -- requirements
Module: ddram_arb

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 3, number of read requesters (2..8).
REQ-002 SHALL have parameter CID_W, default $clog2(NUM_CLIENTS), owner-index width.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port c_rd_req  input  NUM_CLIENTS  per-client read request, level, held until c_rd_ack.
REQ-006 SHALL have port c_rd_addr  input  NUM_CLIENTS*29  per-client 64-bit-word address.
REQ-007 SHALL have port c_rd_burstcnt  input  NUM_CLIENTS*8  per-client burst length, 1..128.
REQ-008 SHALL have port c_rd_ack  output  NUM_CLIENTS  one-cycle pulse: client request accepted downstream.
REQ-009 SHALL have port c_rd_data  output  64  read data, broadcast to all clients.
REQ-010 SHALL have port c_rd_valid  output  NUM_CLIENTS  per-client beat strobe; only the owner's bit may be high.
REQ-011 SHALL have port m_rd_req / m_rd_addr / m_rd_burstcnt  output  1/29/8  to DDR controller read channel.
REQ-012 SHALL have port m_rd_ack  input  1  controller acceptance pulse.
REQ-013 SHALL have port m_rd_data / m_rd_data_valid  input  64/1  controller read return.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DATA; exactly one read outstanding at a time.
REQ-016 IDLE: if any c_rd_req high, SHALL pick winner by round-robin, register owner, latch addr/burstcnt to m_rd_*, assert m_rd_req next cycle, go ISSUE.
REQ-017 Round-robin: search starts at (last_owner+1) mod NUM_CLIENTS; last_owner resets to NUM_CLIENTS-1 so client 0 wins first.
REQ-018 ISSUE: on m_rd_ack SHALL drop m_rd_req next cycle, pulse c_rd_ack[owner] for one cycle, load beat counter with burstcnt, go DATA.
REQ-019 DATA: each m_rd_data_valid SHALL raise c_rd_valid[owner] combinationally in the same cycle and decrement counter; at last beat (counter==1) go IDLE.
REQ-020 Grant latency: c_rd_req in IDLE -> m_rd_req asserted 1 cycle later; new arbitration possible the cycle after final beat.
REQ-021 burstcnt 0 SHALL be clamped to 1; values >128 passed unmodified (client error).
REQ-022 m_rd_data_valid outside DATA SHALL be discarded (no c_rd_valid bit set).
REQ-023 Requests arriving during ISSUE/DATA SHALL wait; c_rd_req dropped before c_rd_ack is a client error, latched request still completes.
REQ-024 m_rd_ack in same cycle as entering ISSUE SHALL not occur (m_rd_req registered); ack outside ISSUE ignored.

Reset
REQ-025 Reset SHALL force IDLE, m_rd_req=0, c_rd_ack=0, busy=0, counter=0, last_owner=NUM_CLIENTS-1; m_rd_addr/burstcnt/data undefined-safe (held 0).
REQ-026 Reset mid-burst SHALL abandon the transfer; subsequent stray beats discarded per REQ-022.

Configuration
REQ-027 Macro DDRAM_ARB_STATS_EN defined: SHALL add output stat_grants (NUM_CLIENTS*16), per-client grant counters incremented on c_rd_ack, saturating at 16'hFFFF, cleared by reset.
REQ-028 Macro DDRAM_ARB_STATS_EN undefined: port and counters absent; behaviour otherwise identical.

Structure
REQ-029 Package ddram_arb_pkg SHALL hold state enum (IDLE/ISSUE/DATA), ADDR_W=29, BURST_W=8, DATA_W=64, STAT_W=16.
REQ-030 Sub-module rr_pick SHALL implement combinational round-robin select (req vector, last index -> valid, winner index).

Verification
REQ-031 Single client 1, addr 0x100, burst 4 -> m_rd_addr=0x100, burstcnt=4; four beats raise only c_rd_valid[1]; busy low after 4th beat.
REQ-032 Clients 0,1,2 all requesting bursts of 2 continuously -> grant order 0,1,2,0,1,2; no c_rd_ack overlap.
REQ-033 Controller holds m_rd_ack low 10 cycles -> m_rd_req stays high, addr stable; c_rd_ack pulses exactly once after ack.
REQ-034 burstcnt=0 request -> m_rd_burstcnt=1, one beat returned, IDLE after it.
REQ-035 Reset asserted after 2 of 8 beats -> IDLE, busy=0; remaining 6 beats produce no c_rd_valid; next request (client 0) served normally.
REQ-036 With DDRAM_ARB_STATS_EN, 3 grants to client 2 -> stat_grants slice 2 = 3, others 0.

Source files
------------

// File: rtl/ddram_arb_pkg.sv
// ddram_arb_pkg: shared types and widths for the DDR read arbiter.
//   state_e      - arbiter states IDLE / ISSUE / DATA
//   ADDR_W       - 64-bit-word address width (29)
//   BURST_W      - burst count width (8)
//   DATA_W       - read data width (64)
//   STAT_W       - per-client grant counter width (16)
//   clamp_burst  - maps a zero burst length to one beat
package ddram_arb_pkg;

    localparam int ADDR_W  = 29;
    localparam int BURST_W = 8;
    localparam int DATA_W  = 64;
    localparam int STAT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_e;

    // A zero-length burst would leave the beat counter unable to terminate,
    // so it is promoted to a single beat. Oversized values pass through.
    function automatic logic [BURST_W-1:0] clamp_burst(input logic [BURST_W-1:0] b);
        return (b == '0) ? BURST_W'(1) : b;
    endfunction

endpackage

// File: rtl/ddram_arb_if.sv
// ddram_arb_if: read channel between the arbiter and the DDR controller.
//   m_rd_req / m_rd_addr / m_rd_burstcnt : arbiter -> controller request
//   m_rd_ack                             : controller acceptance pulse
//   m_rd_data / m_rd_data_valid          : controller read return
// Modports: master (arbiter side), slave (controller side).
interface ddram_arb_if;
    import ddram_arb_pkg::*;

    logic               m_rd_req;
    logic [ADDR_W-1:0]  m_rd_addr;
    logic [BURST_W-1:0] m_rd_burstcnt;
    logic               m_rd_ack;
    logic [DATA_W-1:0]  m_rd_data;
    logic               m_rd_data_valid;

    modport master (
        output m_rd_req, m_rd_addr, m_rd_burstcnt,
        input  m_rd_ack, m_rd_data, m_rd_data_valid
    );

    modport slave (
        input  m_rd_req, m_rd_addr, m_rd_burstcnt,
        output m_rd_ack, m_rd_data, m_rd_data_valid
    );

endinterface

// File: rtl/ddram_arb_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   - request vector, one bit per client
//   last  - index of the previous winner
//   valid - at least one request present
//   win   - first requesting index found searching from last+1, wrapping
module rr_pick #(
    parameter int N     = 3,
    parameter int CID_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [CID_W-1:0] last,
    output logic             valid,
    output logic [CID_W-1:0] win
);

    logic [CID_W-1:0] idx;

    always_comb begin
        valid = 1'b0;
        win   = '0;
        idx   = '0;
        // k runs 1..N so the previous winner is considered last.
        for (int k = 1; k <= N; k++) begin
            idx = CID_W'((int'(last) + k) % N);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                win   = idx;
            end
        end
    end

endmodule

// File: rtl/ddram_arb.sv
// ddram_arb: round-robin arbiter sharing one DDR read channel among
// NUM_CLIENTS requesters, one read outstanding at a time.
//   clk, reset      - clock, synchronous active-high reset
//   c_rd_req        - per-client level request, held until c_rd_ack
//   c_rd_addr       - per-client word address
//   c_rd_burstcnt   - per-client burst length (0 treated as 1)
//   c_rd_ack        - one-cycle pulse to the owner when the controller accepts
//   c_rd_data       - controller read data, broadcast
//   c_rd_valid      - beat strobe, only the owner's bit can be set
//   m               - controller read channel (ddram_arb_if.master)
//   busy            - high whenever not IDLE
//   stat_grants     - per-client saturating grant counters, present only
//                     when the DDRAM_ARB_STATS_EN macro is defined
module ddram_arb
    import ddram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter int CID_W       = $clog2(NUM_CLIENTS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_CLIENTS-1:0]                c_rd_req,
    input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]    c_rd_addr,
    input  logic [NUM_CLIENTS-1:0][BURST_W-1:0]   c_rd_burstcnt,
    output logic [NUM_CLIENTS-1:0]                c_rd_ack,
    output logic [DATA_W-1:0]                     c_rd_data,
    output logic [NUM_CLIENTS-1:0]                c_rd_valid,
    ddram_arb_if.master                           m,
    output logic                                  busy
`ifdef DDRAM_ARB_STATS_EN
    ,
    output logic [NUM_CLIENTS-1:0][STAT_W-1:0]    stat_grants
`endif
);

    localparam logic [CID_W-1:0] LAST_RST = CID_W'(NUM_CLIENTS - 1);

    state_e                  state_q, state_d;
    logic [CID_W-1:0]        owner_q, owner_d;
    logic [CID_W-1:0]        last_owner_q, last_owner_d;
    logic                    m_req_q, m_req_d;
    logic [ADDR_W-1:0]       m_addr_q, m_addr_d;
    logic [BURST_W-1:0]      m_burst_q, m_burst_d;
    logic [BURST_W-1:0]      cnt_q, cnt_d;
    logic [NUM_CLIENTS-1:0]  ack_q, ack_d;

    logic                    pick_valid;
    logic [CID_W-1:0]        pick_idx;
    logic [NUM_CLIENTS-1:0]  owner_oh;

    rr_pick #(.N(NUM_CLIENTS), .CID_W(CID_W)) u_pick (
        .req   (c_rd_req),
        .last  (last_owner_q),
        .valid (pick_valid),
        .win   (pick_idx)
    );

    assign owner_oh = NUM_CLIENTS'(1) << owner_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        m_req_d      = m_req_q;
        m_addr_d     = m_addr_q;
        m_burst_d    = m_burst_q;
        cnt_d        = cnt_q;
        ack_d        = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d      = pick_idx;
                    last_owner_d = pick_idx;
                    m_addr_d     = c_rd_addr[pick_idx];
                    m_burst_d    = clamp_burst(c_rd_burstcnt[pick_idx]);
                    m_req_d      = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (m.m_rd_ack) begin
                    m_req_d = 1'b0;
                    ack_d   = owner_oh;
                    cnt_d   = m_burst_q;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (m.m_rd_data_valid) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == BURST_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_RST;
            m_req_q      <= 1'b0;
            m_addr_q     <= '0;
            m_burst_q    <= '0;
            cnt_q        <= '0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            m_req_q      <= m_req_d;
            m_addr_q     <= m_addr_d;
            m_burst_q    <= m_burst_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
        end
    end

    assign m.m_rd_req      = m_req_q;
    assign m.m_rd_addr     = m_addr_q;
    assign m.m_rd_burstcnt = m_burst_q;
    assign c_rd_ack        = ack_q;
    assign c_rd_data       = m.m_rd_data;
    assign busy            = (state_q != IDLE);
    // Beats are forwarded in the same cycle; anything outside DATA is dropped.
    assign c_rd_valid      = (state_q == DATA && m.m_rd_data_valid) ? owner_oh : '0;

`ifdef DDRAM_ARB_STATS_EN
    logic [NUM_CLIENTS-1:0][STAT_W-1:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (ack_q[i] && stat_q[i] != {STAT_W{1'b1}})
                stat_d[i] = stat_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) stat_q <= '0;
        else       stat_q <= stat_d;
    end

    assign stat_grants = stat_q;
`endif

endmodule
